// File: rtl/voxel_dda_stepper_pkg.sv
// Shared types for the voxel DDA ray stepper: fixed-point scalars, vectors,
// block coordinates and block types, FSM states and the saturating adder.
package voxel_dda_stepper_pkg;

  localparam int FIXED_W = 32;
  localparam int COORD_W = 16;
  localparam int ADDR_W  = 8;

  // Q16.16 signed fixed point; ray distances are never negative, so the
  // largest positive code doubles as "this axis never crosses a boundary".
  typedef logic signed [FIXED_W-1:0] fixed;
  localparam fixed FIXED_1   = 32'sh0001_0000;
  localparam fixed FIXED_MAX = 32'sh7FFF_FFFF;

  // Index 0 = x, 1 = y, 2 = z.
  typedef fixed [2:0] vec3;

  typedef logic signed [COORD_W-1:0] coord_t;
  typedef coord_t [2:0] vec3i;

  typedef struct packed {
    logic [ADDR_W-1:0] z;
    logic [ADDR_W-1:0] y;
    logic [ADDR_W-1:0] x;
  } BlockPos;

  typedef enum logic [3:0] {
    BLOCK_AIR   = 4'd0,
    BLOCK_STONE = 4'd1,
    BLOCK_DIRT  = 4'd2,
    BLOCK_WATER = 4'd3
  } BlockType;

  typedef enum logic [2:0] {
    S_IDLE,
    S_BOUNDS,
    S_FETCH,
    S_WAIT,
    S_STEP,
    S_DONE
  } dda_state_t;

  typedef enum logic [1:0] {
    AXIS_X = 2'd0,
    AXIS_Y = 2'd1,
    AXIS_Z = 2'd2
  } axis_t;

  // Non-negative add that pins at FIXED_MAX, so an axis that has run off to
  // "infinity" stays there instead of wrapping back into contention.
  function automatic fixed sat_add(input fixed a, input fixed b);
    logic [FIXED_W:0] sum;
    sum = {1'b0, a} + {1'b0, b};
    if (sum >= {1'b0, FIXED_MAX}) return FIXED_MAX;
    return fixed'(sum[FIXED_W-1:0]);
  endfunction

endpackage

// File: rtl/voxel_dda_stepper_if.sv
// Ray-start handshake, result handshake and block-RAM read port of the stepper.
interface voxel_dda_stepper_if
  import voxel_dda_stepper_pkg::*;
#(
  parameter int STEP_BITS = 7
) ();

  logic                 start_valid;
  logic                 start_ready;
  vec3i                 ray_pos_in;
  logic [2:0]           ray_step_in;
  vec3                  t_max_in;
  vec3                  t_delta_in;

  logic                 result_valid;
  logic                 result_ready;
  BlockType             hit_block;
  vec3i                 hit_pos;
  vec3                  hit_norm;
  logic                 hit_miss;
  logic [STEP_BITS-1:0] hit_steps;

  BlockPos              ram_addr;
  logic                 ram_read_enable;
  BlockType             ram_out;
  logic                 ram_valid;

  modport master (
    output start_valid, ray_pos_in, ray_step_in, t_max_in, t_delta_in,
    output result_ready, ram_out, ram_valid,
    input  start_ready, result_valid, hit_block, hit_pos, hit_norm,
    input  hit_miss, hit_steps, ram_addr, ram_read_enable
  );

  modport slave (
    input  start_valid, ray_pos_in, ray_step_in, t_max_in, t_delta_in,
    input  result_ready, ram_out, ram_valid,
    output start_ready, result_valid, hit_block, hit_pos, hit_norm,
    output hit_miss, hit_steps, ram_addr, ram_read_enable
  );

endinterface

// File: rtl/voxel_dda_stepper_axis_select.sv
// Picks the axis with the smallest t_max (ties go x, then y, then z) and
// flags when every axis is parked at FIXED_MAX.
module dda_axis_select
  import voxel_dda_stepper_pkg::*;
(
  input  fixed  i_t_x,
  input  fixed  i_t_y,
  input  fixed  i_t_z,
  output axis_t o_axis,
  output logic  o_all_max
);

  logic w_x_le_y;
  logic w_x_le_z;
  logic w_y_le_z;

  // FIXED_MAX is the largest legal t, so a plain <= already keeps parked axes
  // out unless all three are parked, which o_all_max reports separately.
  always_comb begin
    w_x_le_y  = $unsigned(i_t_x) <= $unsigned(i_t_y);
    w_x_le_z  = $unsigned(i_t_x) <= $unsigned(i_t_z);
    w_y_le_z  = $unsigned(i_t_y) <= $unsigned(i_t_z);
    o_all_max = (i_t_x == FIXED_MAX) && (i_t_y == FIXED_MAX) && (i_t_z == FIXED_MAX);
    if (w_x_le_y && w_x_le_z) o_axis = AXIS_X;
    else if (w_y_le_z)        o_axis = AXIS_Y;
    else                      o_axis = AXIS_Z;
  end

endmodule

// File: rtl/voxel_dda_stepper.sv
// Amanatides-Woo style voxel walker: tests the start voxel, then steps one
// voxel at a time along the nearest boundary until a solid block, the grid
// edge or the step budget ends the ray.
module voxel_dda_stepper
  import voxel_dda_stepper_pkg::*;
#(
  parameter int GRID_BITS_X = 4,
  parameter int GRID_BITS_Y = 4,
  parameter int GRID_BITS_Z = 4,
  parameter int MAX_STEPS   = 64
) (
  input  logic               clk_in,
  input  logic               rst_in,
  voxel_dda_stepper_if.slave bus
);

  localparam int STEP_BITS = $clog2(MAX_STEPS + 1);
  localparam logic [COORD_W-1:0] GRID_MAX_X = COORD_W'((1 << GRID_BITS_X) - 1);
  localparam logic [COORD_W-1:0] GRID_MAX_Y = COORD_W'((1 << GRID_BITS_Y) - 1);
  localparam logic [COORD_W-1:0] GRID_MAX_Z = COORD_W'((1 << GRID_BITS_Z) - 1);

  dda_state_t           r_state;
  dda_state_t           w_state_next;
  vec3i                 r_pos;
  logic [2:0]           r_dir;
  vec3                  r_t_max;
  vec3                  r_t_delta;
  vec3                  r_norm;
  logic [STEP_BITS-1:0] r_steps;
  BlockType             r_block;
  logic                 r_miss;

  logic                 w_oob;
  logic                 w_budget;
  logic                 w_hit;
  logic                 w_all_max;
  axis_t                w_axis;
  coord_t               w_pos_next;
  fixed                 w_t_next;
  vec3                  w_norm_next;

  dda_axis_select u_axis_select (
    .i_t_x     (r_t_max[0]),
    .i_t_y     (r_t_max[1]),
    .i_t_z     (r_t_max[2]),
    .o_axis    (w_axis),
    .o_all_max (w_all_max)
  );

  // A negative coordinate reads as a huge unsigned value, so one unsigned
  // compare per axis catches both ends of the grid.
  assign w_oob = ($unsigned(r_pos[0]) > GRID_MAX_X) ||
                 ($unsigned(r_pos[1]) > GRID_MAX_Y) ||
                 ($unsigned(r_pos[2]) > GRID_MAX_Z);
  assign w_budget = (r_steps == STEP_BITS'(MAX_STEPS));
  assign w_hit    = bus.ram_valid && (bus.ram_out != BLOCK_AIR);

  assign w_pos_next = r_pos[w_axis] + (r_dir[w_axis] ? coord_t'(1) : coord_t'(-1));
  assign w_t_next   = sat_add(r_t_max[w_axis], r_t_delta[w_axis]);

  // Entry face normal points against the direction of travel on the stepped axis.
  always_comb begin
    w_norm_next         = '0;
    w_norm_next[w_axis] = r_dir[w_axis] ? -FIXED_1 : FIXED_1;
  end

  assign bus.start_ready     = (r_state == S_IDLE);
  assign bus.result_valid    = (r_state == S_DONE);
  assign bus.ram_read_enable = (r_state == S_FETCH);
  assign bus.ram_addr        = {r_pos[2][ADDR_W-1:0], r_pos[1][ADDR_W-1:0], r_pos[0][ADDR_W-1:0]};
  assign bus.hit_block       = r_block;
  assign bus.hit_pos         = r_pos;
  assign bus.hit_norm        = r_norm;
  assign bus.hit_miss        = r_miss;
  assign bus.hit_steps       = r_steps;

  // State register.
  always_ff @(posedge clk_in) begin
    if (!rst_in) r_state <= S_IDLE;
    else         r_state <= w_state_next;
  end

  // Next-state logic; ram_valid only matters while a read is outstanding.
  always_comb begin
    w_state_next = r_state;
    case (r_state)
      S_IDLE:   if (bus.start_valid) w_state_next = S_BOUNDS;
      S_BOUNDS: w_state_next = (w_oob || w_budget) ? S_DONE : S_FETCH;
      S_FETCH:  w_state_next = S_WAIT;
      S_WAIT:   if (bus.ram_valid) w_state_next = w_hit ? S_DONE : S_STEP;
      S_STEP:   w_state_next = w_all_max ? S_DONE : S_BOUNDS;
      S_DONE:   if (bus.result_ready) w_state_next = S_IDLE;
      default:  w_state_next = S_IDLE;
    endcase
  end

  // Ray datapath: capture on start, advance on STEP, latch the verdict.
  always_ff @(posedge clk_in) begin
    if (!rst_in) begin
      r_pos     <= '0;
      r_dir     <= '0;
      r_t_max   <= '0;
      r_t_delta <= '0;
      r_norm    <= '0;
      r_steps   <= '0;
      r_block   <= BLOCK_AIR;
      r_miss    <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (bus.start_valid) begin
            r_pos     <= bus.ray_pos_in;
            r_dir     <= bus.ray_step_in;
            r_t_max   <= bus.t_max_in;
            r_t_delta <= bus.t_delta_in;
            r_norm    <= '0;
            r_steps   <= '0;
            r_block   <= BLOCK_AIR;
            r_miss    <= 1'b0;
          end
        end
        S_BOUNDS: begin
          if (w_oob || w_budget) r_miss <= 1'b1;
        end
        S_WAIT: begin
          if (w_hit) r_block <= bus.ram_out;
        end
        S_STEP: begin
          if (w_all_max) begin
            r_miss <= 1'b1;
          end else begin
            r_pos[w_axis]   <= w_pos_next;
            r_t_max[w_axis] <= w_t_next;
            r_norm          <= w_norm_next;
            r_steps         <= r_steps + 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_voxel_dda_stepper.sv
// Scoreboard bench for voxel_dda_stepper: a default-budget instance and a
// MAX_STEPS=4 instance share one bench-side block RAM with variable latency.
module tb_voxel_dda_stepper;
  import voxel_dda_stepper_pkg::*;

  typedef struct {
    BlockType blk;
    vec3i     pos;
    vec3      norm;
    logic     miss;
    int       steps;
    int       latency;
    int       reads;
  } result_t;

  logic       clk = 1'b0;
  logic       rstN;
  logic       sel;
  logic       startValid;
  vec3i       rayPos;
  logic [2:0] rayStep;
  vec3        tMax;
  vec3        tDelta;
  logic       resultReady;
  BlockType   ramOut = BLOCK_AIR;
  logic       ramValid = 1'b0;

  logic       startReady;
  logic       resultValid;
  BlockType   hitBlock;
  vec3i       hitPos;
  vec3        hitNorm;
  logic       hitMiss;
  logic [7:0] hitSteps;
  BlockPos    ramAddr;
  logic       rdEn;

  BlockType   world [0:4095];
  result_t    expQ [$];
  int         checks = 0;
  int         errors = 0;
  int         ramLatency = 1;
  int         ramCnt = 0;
  BlockType   ramData = BLOCK_AIR;
  int         rdTotal = 0;
  int         rdBase = 0;

  always #5 clk = ~clk;

  voxel_dda_stepper_if #(.STEP_BITS(7)) bus0 ();
  voxel_dda_stepper_if #(.STEP_BITS(3)) bus1 ();

  assign bus0.start_valid  = startValid && !sel;
  assign bus1.start_valid  = startValid && sel;
  assign bus0.ray_pos_in   = rayPos;
  assign bus1.ray_pos_in   = rayPos;
  assign bus0.ray_step_in  = rayStep;
  assign bus1.ray_step_in  = rayStep;
  assign bus0.t_max_in     = tMax;
  assign bus1.t_max_in     = tMax;
  assign bus0.t_delta_in   = tDelta;
  assign bus1.t_delta_in   = tDelta;
  assign bus0.result_ready = resultReady && !sel;
  assign bus1.result_ready = resultReady && sel;
  assign bus0.ram_out      = ramOut;
  assign bus1.ram_out      = ramOut;
  assign bus0.ram_valid    = ramValid;
  assign bus1.ram_valid    = ramValid;

  assign startReady  = sel ? bus1.start_ready     : bus0.start_ready;
  assign resultValid = sel ? bus1.result_valid    : bus0.result_valid;
  assign hitBlock    = sel ? bus1.hit_block       : bus0.hit_block;
  assign hitPos      = sel ? bus1.hit_pos         : bus0.hit_pos;
  assign hitNorm     = sel ? bus1.hit_norm        : bus0.hit_norm;
  assign hitMiss     = sel ? bus1.hit_miss        : bus0.hit_miss;
  assign hitSteps    = sel ? 8'(bus1.hit_steps)   : 8'(bus0.hit_steps);
  assign ramAddr     = sel ? bus1.ram_addr        : bus0.ram_addr;
  assign rdEn        = sel ? bus1.ram_read_enable : bus0.ram_read_enable;

  voxel_dda_stepper #(.GRID_BITS_X(4), .GRID_BITS_Y(4), .GRID_BITS_Z(4), .MAX_STEPS(64)) dut0 (
    .clk_in (clk),
    .rst_in (rstN),
    .bus    (bus0.slave)
  );

  voxel_dda_stepper #(.GRID_BITS_X(4), .GRID_BITS_Y(4), .GRID_BITS_Z(4), .MAX_STEPS(4)) dut1 (
    .clk_in (clk),
    .rst_in (rstN),
    .bus    (bus1.slave)
  );

  // Block RAM model: each read request returns world data ramLatency cycles later.
  always @(posedge clk) begin
    ramValid <= 1'b0;
    if (rdEn) begin
      ramCnt  = ramLatency;
      ramData = world[{ramAddr.z[3:0], ramAddr.y[3:0], ramAddr.x[3:0]}];
      rdTotal = rdTotal + 1;
    end
    if (ramCnt != 0) begin
      if (ramCnt == 1) begin
        ramValid <= 1'b1;
        ramOut   <= ramData;
      end
      ramCnt = ramCnt - 1;
    end
  end

  task automatic checkOutput(input string tag, input logic [127:0] actual, input logic [127:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %0h expected %0h", tag, actual, expected);
    end
  endtask

  function automatic vec3i mkPos(input int x, input int y, input int z);
    vec3i v;
    v[0] = coord_t'(x);
    v[1] = coord_t'(y);
    v[2] = coord_t'(z);
    return v;
  endfunction

  function automatic vec3 mk3(input fixed x, input fixed y, input fixed z);
    vec3 v;
    v[0] = x;
    v[1] = y;
    v[2] = z;
    return v;
  endfunction

  function automatic result_t mkExp(input BlockType b, input vec3i p, input vec3 n,
                                    input logic m, input int s, input int l, input int r);
    result_t e;
    e.blk = b; e.pos = p; e.norm = n; e.miss = m; e.steps = s; e.latency = l; e.reads = r;
    return e;
  endfunction

  task automatic clearWorld();
    for (int i = 0; i < 4096; i++) world[i] = BLOCK_AIR;
  endtask

  task automatic setBlock(input int x, input int y, input int z, input BlockType b);
    world[z * 256 + y * 16 + x] = b;
  endtask

  task automatic applyStimulus(input string name, input vec3i pos, input logic [2:0] dir,
                               input vec3 tm, input vec3 td, input result_t exp);
    int n;
    @(negedge clk);
    rayPos     = pos;
    rayStep    = dir;
    tMax       = tm;
    tDelta     = td;
    startValid = 1'b1;
    n = 0;
    while (!startReady && n < 100) begin
      @(negedge clk);
      n++;
    end
    checkOutput({name, "_start_ready"}, 128'(startReady), 128'(1));
    rdBase = rdTotal;
    expQ.push_back(exp);
    @(posedge clk);
    #1;
    startValid = 1'b0;
  endtask

  task automatic waitResult(input string name);
    result_t exp;
    int lat;
    lat = 0;
    while (!resultValid && lat < 500) begin
      @(posedge clk);
      #1;
      lat++;
    end
    checkOutput({name, "_result_valid"}, 128'(resultValid), 128'(1));
    if (!resultValid) begin
      expQ.delete();
      return;
    end
    checkOutput({name, "_queued"}, 128'(expQ.size()), 128'(1));
    if (expQ.size() == 0) return;
    exp = expQ.pop_front();
    checkOutput({name, "_block"}, 128'(hitBlock), 128'(exp.blk));
    checkOutput({name, "_pos"},   128'(hitPos),   128'(exp.pos));
    checkOutput({name, "_norm"},  128'(hitNorm),  128'(exp.norm));
    checkOutput({name, "_miss"},  128'(hitMiss),  128'(exp.miss));
    checkOutput({name, "_steps"}, 128'(hitSteps), 128'(exp.steps));
    if (exp.latency >= 0) checkOutput({name, "_latency"}, 128'(lat), 128'(exp.latency));
    if (exp.reads >= 0)   checkOutput({name, "_reads"}, 128'(rdTotal - rdBase), 128'(exp.reads));
    @(negedge clk);
    resultReady = 1'b1;
    @(posedge clk);
    #1;
    resultReady = 1'b0;
    checkOutput({name, "_valid_drop"}, 128'(resultValid), 128'(0));
    checkOutput({name, "_idle_again"}, 128'(startReady), 128'(1));
  endtask

  task automatic checkResetState(input string name);
    checkOutput({name, "_start_ready"},  128'(startReady),  128'(1));
    checkOutput({name, "_result_valid"}, 128'(resultValid), 128'(0));
    checkOutput({name, "_rd_en"},        128'(rdEn),        128'(0));
    checkOutput({name, "_ram_addr"},     128'(ramAddr),     128'(0));
    checkOutput({name, "_block"},        128'(hitBlock),    128'(BLOCK_AIR));
    checkOutput({name, "_pos"},          128'(hitPos),      128'(0));
    checkOutput({name, "_norm"},         128'(hitNorm),     128'(0));
    checkOutput({name, "_miss"},         128'(hitMiss),     128'(0));
    checkOutput({name, "_steps"},        128'(hitSteps),    128'(0));
  endtask

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation did not finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    vec3 xRay;
    vec3 xDelta;
    int n;
    xRay   = mk3(32'sh0000_8000, FIXED_MAX, FIXED_MAX);
    xDelta = mk3(FIXED_1, FIXED_MAX, FIXED_MAX);
    rstN = 1'b0; sel = 1'b0; startValid = 1'b0; resultReady = 1'b0;
    rayPos = '0; rayStep = '0; tMax = '0; tDelta = '0;
    clearWorld();
    repeat (3) @(posedge clk);
    #1;
    checkResetState("por");
    rstN = 1'b1;

    $display("[TB] stone three voxels down +x");
    setBlock(5, 2, 2, BLOCK_STONE);
    applyStimulus("stone", mkPos(2, 2, 2), 3'b111, xRay, xDelta,
                  mkExp(BLOCK_STONE, mkPos(5, 2, 2), mk3(-FIXED_1, 0, 0), 1'b0, 3, 15, 4));
    waitResult("stone");

    $display("[TB] empty grid exits at x=16");
    clearWorld();
    applyStimulus("exit", mkPos(2, 2, 2), 3'b111, xRay, xDelta,
                  mkExp(BLOCK_AIR, mkPos(16, 2, 2), mk3(-FIXED_1, 0, 0), 1'b1, 14, -1, 14));
    waitResult("exit");

    $display("[TB] three-way tie steps x then y");
    setBlock(3, 3, 2, BLOCK_WATER);
    applyStimulus("tie", mkPos(2, 2, 2), 3'b111, mk3(FIXED_1, FIXED_1, FIXED_1),
                  mk3(FIXED_1, FIXED_1, FIXED_1),
                  mkExp(BLOCK_WATER, mkPos(3, 3, 2), mk3(0, -FIXED_1, 0), 1'b0, 2, -1, 3));
    waitResult("tie");

    $display("[TB] solid start voxel");
    clearWorld();
    setBlock(2, 2, 2, BLOCK_DIRT);
    applyStimulus("start_hit", mkPos(2, 2, 2), 3'b111, xRay, xDelta,
                  mkExp(BLOCK_DIRT, mkPos(2, 2, 2), mk3(0, 0, 0), 1'b0, 0, 3, 1));
    waitResult("start_hit");

    $display("[TB] -x ray leaves below zero");
    clearWorld();
    applyStimulus("neg", mkPos(1, 5, 5), 3'b110, xRay, xDelta,
                  mkExp(BLOCK_AIR, mkPos(-1, 5, 5), mk3(FIXED_1, 0, 0), 1'b1, 2, -1, 2));
    waitResult("neg");

    $display("[TB] all axes parked at FIXED_MAX");
    applyStimulus("allmax", mkPos(7, 7, 7), 3'b111, mk3(FIXED_MAX, FIXED_MAX, FIXED_MAX), xDelta,
                  mkExp(BLOCK_AIR, mkPos(7, 7, 7), mk3(0, 0, 0), 1'b1, 0, 4, 1));
    waitResult("allmax");

    $display("[TB] start outside the grid");
    applyStimulus("outside", mkPos(20, 0, 0), 3'b111, xRay, xDelta,
                  mkExp(BLOCK_AIR, mkPos(20, 0, 0), mk3(0, 0, 0), 1'b1, 0, 1, 0));
    waitResult("outside");

    $display("[TB] start while busy is ignored");
    setBlock(5, 2, 2, BLOCK_STONE);
    applyStimulus("busy", mkPos(2, 2, 2), 3'b111, xRay, xDelta,
                  mkExp(BLOCK_STONE, mkPos(5, 2, 2), mk3(-FIXED_1, 0, 0), 1'b0, 3, -1, 4));
    @(negedge clk);
    rayPos = mkPos(9, 9, 9);
    startValid = 1'b1;
    repeat (3) @(negedge clk);
    checkOutput("busy_start_ready", 128'(startReady), 128'(0));
    startValid = 1'b0;
    waitResult("busy");

    $display("[TB] step budget of 4 with 3-cycle RAM");
    sel = 1'b1;
    ramLatency = 3;
    clearWorld();
    applyStimulus("budget", mkPos(2, 2, 2), 3'b111, xRay, xDelta,
                  mkExp(BLOCK_AIR, mkPos(6, 2, 2), mk3(-FIXED_1, 0, 0), 1'b1, 4, -1, 4));
    waitResult("budget");
    setBlock(4, 2, 2, BLOCK_STONE);
    applyStimulus("slow_hit", mkPos(2, 2, 2), 3'b111, xRay, xDelta,
                  mkExp(BLOCK_STONE, mkPos(4, 2, 2), mk3(-FIXED_1, 0, 0), 1'b0, 2, -1, 3));
    waitResult("slow_hit");

    $display("[TB] reset during WAIT, late ram_valid");
    sel = 1'b0;
    clearWorld();
    setBlock(2, 2, 2, BLOCK_STONE);
    applyStimulus("abort", mkPos(2, 2, 2), 3'b111, xRay, xDelta,
                  mkExp(BLOCK_STONE, mkPos(2, 2, 2), mk3(0, 0, 0), 1'b0, 0, -1, 1));
    n = 0;
    while (!rdEn && n < 50) begin
      @(posedge clk);
      #1;
      n++;
    end
    checkOutput("abort_fetch_seen", 128'(rdEn), 128'(1));
    @(posedge clk);
    #1;
    @(negedge clk);
    rstN = 1'b0;
    @(posedge clk);
    #1;
    rstN = 1'b1;
    expQ.delete();
    checkResetState("midrst");
    repeat (6) @(posedge clk);
    #1;
    checkOutput("late_valid_idle",  128'(startReady),  128'(1));
    checkOutput("late_valid_noval", 128'(resultValid), 128'(0));

    clearWorld();
    setBlock(5, 2, 2, BLOCK_STONE);
    applyStimulus("after_rst", mkPos(2, 2, 2), 3'b111, xRay, xDelta,
                  mkExp(BLOCK_STONE, mkPos(5, 2, 2), mk3(-FIXED_1, 0, 0), 1'b0, 3, -1, 4));
    waitResult("after_rst");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
